ct_spsram_256x59_ctrl: RTL
==========================

Name: ct_spsram_256x59_ctrl

Overview:
- Initiator and controller that drives one 256x59 single-port SRAM macro: pins A, CEN, GWEN, WEN, D out; Q in.
- Clears the whole array after reset, then arbitrates a valid/ready request port onto the SRAM.
- Buffers read data in a small response FIFO, so response back-pressure never loses Q.
- Sits between a core-side cache/tag pipeline and the SRAM wrapper.

Parameters:
- ADDR_WIDTH, 8, SRAM address width (depth = 2**ADDR_WIDTH).
- DATA_WIDTH, 59, data and bit-write-enable width.
- RSP_DEPTH, 2, response FIFO entries; must be >= 2.
- INIT_EN, 1, 1 = zero-fill the array after reset; 0 = go to RUN directly.

Ports:
- forever_cpuclk  in  1  clock; SRAM CLK is driven from the same clock.
- cpurst  in  1  synchronous, active-high reset.
- req_vld  in  1  request valid.
- req_rdy  out  1  request ready.
- req_wr  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_WIDTH  access address.
- req_wdata  in  DATA_WIDTH  write data.
- req_wmask  in  DATA_WIDTH  active-high per-bit write enable.
- rsp_vld  out  1  read data valid.
- rsp_rdy  in  1  read data accepted.
- rsp_rdata  out  DATA_WIDTH  read data.
- init_done  out  1  high once the array is cleared and the block is in RUN.
- sram_a  out  ADDR_WIDTH  to SRAM A.
- sram_cen  out  1  to SRAM CEN, active-low.
- sram_gwen  out  1  to SRAM GWEN, active-low global write.
- sram_wen  out  DATA_WIDTH  to SRAM WEN, active-low per bit.
- sram_d  out  DATA_WIDTH  to SRAM D.
- sram_q  in  DATA_WIDTH  from SRAM Q.

Behaviour:
- Reset (cpurst=1, sampled on the clock edge):
  - State goes to INIT (INIT_EN=1) or RUN (INIT_EN=0).
  - init_addr=0, FIFO emptied, rd_inflight=0.
  - While cpurst is high: req_rdy=0, rsp_vld=0, init_done=0, sram_cen=1, sram_gwen=1, sram_wen=all 1, sram_a=0, sram_d=0.
- INIT state:
  - Each cycle: sram_cen=0, sram_gwen=0, sram_wen=all 0, sram_d=0, sram_a=init_addr; init_addr increments.
  - Leaves for RUN after writing address 2**ADDR_WIDTH-1; the sweep takes 256 cycles.
  - The address counter must never wrap back to 0 and issue a second sweep.
  - req_rdy=0 throughout INIT.
- RUN state: init_done=1.
  - Request fires when req_vld & req_rdy.
  - SRAM pins are driven combinationally from the fired request in the same cycle:
    - sram_cen=0, sram_a=req_addr, sram_d=req_wdata.
    - Write: sram_gwen=0, sram_wen=~req_wmask.
    - Read: sram_gwen=1, sram_wen=all 1.
  - No fire: sram_cen=1, sram_gwen=1, sram_wen=all 1. sram_a and sram_d hold their last values (don't care to the SRAM, but must not toggle, for power).
- Writes:
  - Accepted whenever in RUN; produce no response.
  - req_wmask=0 with req_wr=1 is still a legal SRAM cycle (CEN low, nothing changes).
- Reads:
  - Read accepted in cycle t: rd_inflight=1 in t+1; sram_q is pushed into the FIFO at the end of t+1.
  - rsp_vld rises in t+2. Fixed latency is 2 cycles with the FIFO empty.
  - rsp_rdata is the FIFO head, registered.
- Read flow control:
  - Read acceptance: req_rdy = RUN & (req_wr | (fifo_count + rd_inflight - pop) < RSP_DEPTH), where pop = rsp_vld & rsp_rdy.
  - Data can therefore never be lost.
  - With rsp_rdy held high, back-to-back reads sustain 1 per cycle.
- Simultaneous push and pop: count unchanged, order preserved.
- Read-after-write to the same address in the next cycle returns the new data (SRAM native behaviour, no bypass logic).
- rsp_vld, once high, holds rsp_rdata stable until popped.
- FIFO pointers use log2(RSP_DEPTH) bits and wrap modulo RSP_DEPTH; count uses log2(RSP_DEPTH)+1 bits.
- Reset mid-INIT or mid-RUN: FIFO contents and in-flight reads are discarded; INIT restarts from address 0.

Decomposition:
- Package ct_spsram_ctrl_pkg holds:
  - Constants SRAM_ADDR_WIDTH=8 and SRAM_DATA_WIDTH=59.
  - Encoded state type {INIT, RUN}.
  - Helper for the FIFO pointer width.
- One sub-module, ct_spsram_rsp_fifo:
  - Parameterised DATA_WIDTH/RSP_DEPTH, synchronous active-high reset.
  - push/pop/count ports; full/empty derived from count.
- FSM, init counter, pin muxing and credit check stay in the top.

Test Plan:
- Init sweep: release reset, INIT_EN=1 -> sram_cen low for exactly 256 cycles, sram_a 0x00..0xFF, sram_wen=all 0, sram_d=0; init_done rises on cycle 257; reading 0x7F returns 0.
- Masked write: write addr 0x10, wdata=all 1, wmask=0x0FF_FFFF_FFFF_FFFF, then read 0x10 -> sram_wen=0x700_0000_0000_0000; rsp_rdata=0x0FF_FFFF_FFFF_FFFF exactly 2 cycles after the read is accepted.
- Back-pressure: rsp_rdy=0, issue 4 reads -> 2 accepted, req_rdy drops; raise rsp_rdy -> responses returned in issue order, no loss, remaining reads accepted.
- Throughput: rsp_rdy=1, 16 back-to-back reads -> req_rdy never drops; rsp_vld continuous for 16 cycles starting 2 cycles after the first read.
- Reset mid-operation:
  - Assert cpurst at init_addr=100 -> next sweep starts at 0 and lasts 256 cycles.
  - Assert cpurst with 2 responses buffered -> rsp_vld=0 after reset, no stale data emerges.
- Read-after-write: write 0x55 with data A, then read 0x55 in the next cycle -> rsp_rdata=A.

Source files
------------

// File: rtl/ct_spsram_ctrl_pkg.sv
// Shared constants and types for the 256x59 single-port SRAM controller.
//   SRAM_ADDR_WIDTH / SRAM_DATA_WIDTH : macro geometry
//   state_e                           : controller state encoding
//   ptr_width()                       : FIFO pointer width for a given depth
package ct_spsram_ctrl_pkg;

  localparam int unsigned SRAM_ADDR_WIDTH = 8;
  localparam int unsigned SRAM_DATA_WIDTH = 59;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

  // log2(depth) bits, never narrower than one bit
  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/ct_spsram_rsp_fifo.sv
// Small response FIFO holding SRAM read data until the consumer accepts it.
//   clk, rst   : clock, synchronous active-high reset
//   push       : write push_data at the tail
//   pop        : drop the head entry (ignored when empty)
//   head       : current head entry (registered storage)
//   count      : number of valid entries
//   empty      : count == 0
module ct_spsram_rsp_fifo
  import ct_spsram_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = SRAM_DATA_WIDTH,
  parameter int unsigned RSP_DEPTH  = 2,
  localparam int unsigned PW = ptr_width(RSP_DEPTH),
  localparam int unsigned CW = PW + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head,
  output logic [CW-1:0]         count,
  output logic                  empty
);

  logic [DATA_WIDTH-1:0] mem [RSP_DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic                  full;
  logic                  do_push;
  logic                  do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(RSP_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full    = (count == CW'(RSP_DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  // a full FIFO still accepts a push when the head leaves in the same cycle
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr];

  // pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      if (do_push && !do_pop)      count <= count + CW'(1);
      else if (do_pop && !do_push) count <= count - CW'(1);
    end
  end

  // data storage, no reset needed
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/ct_spsram_256x59_ctrl.sv
// Controller for one 256x59 single-port SRAM: zero-fills the array after
// reset, then maps a valid/ready request port onto the macro pins and
// buffers read data in a response FIFO.
//   forever_cpuclk, cpurst        : clock, synchronous active-high reset
//   req_*                         : request port (valid/ready)
//   rsp_*                         : read response port (valid/ready)
//   init_done                     : array cleared, accepting requests
//   sram_a/cen/gwen/wen/d, sram_q : SRAM macro pins
module ct_spsram_256x59_ctrl
  import ct_spsram_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = SRAM_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = SRAM_DATA_WIDTH,
  parameter int unsigned RSP_DEPTH  = 2,
  parameter bit          INIT_EN    = 1'b1
) (
  input  logic                  forever_cpuclk,
  input  logic                  cpurst,
  input  logic                  req_vld,
  output logic                  req_rdy,
  input  logic                  req_wr,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [DATA_WIDTH-1:0] req_wmask,
  output logic                  rsp_vld,
  input  logic                  rsp_rdy,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  init_done,
  output logic [ADDR_WIDTH-1:0] sram_a,
  output logic                  sram_cen,
  output logic                  sram_gwen,
  output logic [DATA_WIDTH-1:0] sram_wen,
  output logic [DATA_WIDTH-1:0] sram_d,
  input  logic [DATA_WIDTH-1:0] sram_q
);

  localparam int unsigned CW = ptr_width(RSP_DEPTH) + 1;
  localparam int unsigned OW = CW + 1;

  state_e                state;
  logic [ADDR_WIDTH-1:0] init_addr;
  logic [ADDR_WIDTH-1:0] a_hold;
  logic [DATA_WIDTH-1:0] d_hold;
  logic                  rd_inflight;
  logic [CW-1:0]         fifo_count;
  logic                  fifo_empty;
  logic                  run;
  logic                  pop;
  logic                  fire;
  logic [OW-1:0]         occ;

  assign run       = (state == RUN) & ~cpurst;
  assign init_done = run;
  assign rsp_vld   = ~fifo_empty & ~cpurst;
  assign pop       = rsp_vld & rsp_rdy;

  // slots already claimed by buffered and in-flight reads, net of this cycle's pop
  assign occ     = OW'(fifo_count) + OW'(rd_inflight) - OW'(pop);
  assign req_rdy = run & (req_wr | (occ < OW'(RSP_DEPTH)));
  assign fire    = req_vld & req_rdy;

  // SRAM pin mux; address/data hold their last value on idle cycles
  always_comb begin
    sram_cen  = 1'b1;
    sram_gwen = 1'b1;
    sram_wen  = '1;
    sram_a    = a_hold;
    sram_d    = d_hold;
    if (cpurst) begin
      sram_a = '0;
      sram_d = '0;
    end else if (state == INIT) begin
      sram_cen  = 1'b0;
      sram_gwen = 1'b0;
      sram_wen  = '0;
      sram_a    = init_addr;
      sram_d    = '0;
    end else if (fire) begin
      sram_cen = 1'b0;
      sram_a   = req_addr;
      sram_d   = req_wdata;
      if (req_wr) begin
        sram_gwen = 1'b0;
        sram_wen  = ~req_wmask;
      end
    end
  end

  // state, init sweep counter, pin hold registers, read pipeline stage
  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      if (INIT_EN) state <= INIT;
      else         state <= RUN;
      init_addr   <= '0;
      rd_inflight <= 1'b0;
      a_hold      <= '0;
      d_hold      <= '0;
    end else begin
      a_hold      <= sram_a;
      d_hold      <= sram_d;
      rd_inflight <= fire & ~req_wr;
      if (state == INIT) begin
        init_addr <= init_addr + ADDR_WIDTH'(1);
        // leaving INIT after the last address stops any second sweep
        if (init_addr == '1) state <= RUN;
      end
    end
  end

  ct_spsram_rsp_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .RSP_DEPTH  (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk       (forever_cpuclk),
    .rst       (cpurst),
    .push      (rd_inflight),
    .push_data (sram_q),
    .pop       (pop),
    .head      (rsp_rdata),
    .count     (fifo_count),
    .empty     (fifo_empty)
  );

endmodule
